lane_object_compositor: RTL and testbench

Parametrised, pipelined replacement for the per-row car/lily-pad pixel tests in the Frogger video path. It holds a double-buffered table of `LANES` × `SLOTS` fixed-size moving objects, hit-tests each VGA pixel against all of them with wrap-around on the 11-bit X axis, resolves lane priority, and applies per-lane collision flashing. It emits registered RGB to the VGA output. The frog sprite overlay stays downstream and muxes over this block's output.

---
 rtl/lane_object_compositor.sv | 170 +++++++++++++++++
 tb/tb_lane_object_compositor.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_object_compositor.sv
// Double-buffered moving-object table, per-pixel hit test with X/Y wrap, lane priority and flash colouring.
// Fixed 2-cycle latency from Pix_Valid/DrawX/DrawY to RGB; no stall, no backpressure.
module lane_object_compositor #(
    parameter int          LANES        = 8,
    parameter int          SLOTS        = 4,
    parameter int          OBJ_W        = 80,
    parameter int          OBJ_H        = 40,
    parameter int          FLASH_FRAMES = 30,
    parameter logic [23:0] BG_RGB       = 24'hFFFFFF,
    parameter logic [23:0] FLASH_RGB    = 24'hFF0000,
    localparam int         LW           = (LANES > 1) ? $clog2(LANES) : 1,
    localparam int         SW           = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Frame_Start,
    input  logic               Wr_En,
    input  logic [LW-1:0]      Wr_Lane,
    input  logic [SW-1:0]      Wr_Slot,
    input  logic [10:0]        Wr_X,
    input  logic [10:0]        Wr_Y,
    input  logic               Wr_Vis,
    input  logic [24*LANES-1:0] Lane_RGB,
    input  logic [LANES-1:0]   Flash_Req,
    input  logic               Pix_Valid,
    input  logic [10:0]        DrawX,
    input  logic [10:0]        DrawY,
    output logic [7:0]         Red,
    output logic [7:0]         Green,
    output logic [7:0]         Blue,
    output logic               Out_Valid,
    output logic               Hit_Any,
    output logic [LW-1:0]      Hit_Lane
);

    localparam int N = LANES * SLOTS;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        vis;
    } obj_t;

    obj_t             shadow_tbl [N];
    obj_t             active_tbl [N];
    logic [7:0]       flash_cnt  [LANES];

    logic [N-1:0]     hit_raw;
    logic [N-1:0]     s1_hit;
    logic             s1_vld;
    logic [LANES-1:0] lane_hit;
    logic             win_any;
    logic [LW-1:0]    win_lane;
    logic [23:0]      sel_rgb;
    logic [7:0]       sel_cnt;
    logic [23:0]      pix_rgb;

    // Shadow write and shadow->active copy share an edge; the copy sees pre-write shadow.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < N; i++) begin
                shadow_tbl[i] <= '0;
                active_tbl[i] <= '0;
            end
        end else begin
            if (Frame_Start) begin
                for (int i = 0; i < N; i++) begin
                    active_tbl[i] <= shadow_tbl[i];
                end
            end
            for (int l = 0; l < LANES; l++) begin
                for (int s = 0; s < SLOTS; s++) begin
                    if (Wr_En && (Wr_Lane == LW'(l)) && (Wr_Slot == SW'(s))) begin
                        shadow_tbl[l*SLOTS+s] <= '{x: Wr_X, y: Wr_Y, vis: Wr_Vis};
                    end
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int l = 0; l < LANES; l++) begin
                flash_cnt[l] <= 8'd0;
            end
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (Flash_Req[l]) begin
                    flash_cnt[l] <= 8'(FLASH_FRAMES);
                end else if (Frame_Start && (flash_cnt[l] != 8'd0)) begin
                    flash_cnt[l] <= flash_cnt[l] - 8'd1;
                end
            end
        end
    end

    // Modulo-2048 differences make objects near X=2047 wrap onto column 0.
    for (genvar i = 0; i < N; i++) begin : g_hit
        logic [10:0] dx;
        logic [10:0] dy;
        assign dx         = DrawX - active_tbl[i].x;
        assign dy         = DrawY - active_tbl[i].y;
        assign hit_raw[i] = active_tbl[i].vis && (dx < 11'(OBJ_W)) && (dy < 11'(OBJ_H));
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_hit <= '0;
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= Pix_Valid;
            if (Pix_Valid) begin
                s1_hit <= hit_raw;
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_hit[l] = |s1_hit[l*SLOTS +: SLOTS];
    end

    // Scan from the top lane down so the lowest-index hit lane is the last assignment.
    always_comb begin
        win_any  = 1'b0;
        win_lane = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (lane_hit[l]) begin
                win_any  = 1'b1;
                win_lane = LW'(l);
            end
        end
    end

    always_comb begin
        sel_rgb = '0;
        sel_cnt = '0;
        for (int l = 0; l < LANES; l++) begin
            if (win_lane == LW'(l)) begin
                sel_rgb = Lane_RGB[l*24 +: 24];
                sel_cnt = flash_cnt[l];
            end
        end
        if (!win_any) begin
            pix_rgb = BG_RGB;
        end else if ((sel_cnt != 8'd0) && sel_cnt[0]) begin
            pix_rgb = FLASH_RGB;
        end else begin
            pix_rgb = sel_rgb;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Red       <= 8'd0;
            Green     <= 8'd0;
            Blue      <= 8'd0;
            Out_Valid <= 1'b0;
            Hit_Any   <= 1'b0;
            Hit_Lane  <= '0;
        end else begin
            Out_Valid <= s1_vld;
            if (s1_vld) begin
                {Red, Green, Blue} <= pix_rgb;
                Hit_Any            <= win_any;
                Hit_Lane           <= win_lane;
            end
        end
    end

endmodule

// File: tb/tb_lane_object_compositor.sv
// Randomised + directed bench: a reference model predicts each output pixel into a queue, a negedge monitor compares.
module tb_lane_object_compositor;

    localparam int          LANES = 8;
    localparam int          SLOTS = 4;
    localparam int          OBJ_W = 80;
    localparam int          OBJ_H = 40;
    localparam int          FF    = 4;
    localparam logic [23:0] BG    = 24'hFFFFFF;
    localparam logic [23:0] FL    = 24'hFF0000;

    logic         Clk, Reset_n, Frame_Start, Wr_En, Wr_Vis, Pix_Valid;
    logic [2:0]   Wr_Lane;
    logic [1:0]   Wr_Slot;
    logic [10:0]  Wr_X, Wr_Y, DrawX, DrawY;
    logic [191:0] Lane_RGB;
    logic [7:0]   Flash_Req;
    logic [7:0]   Red, Green, Blue;
    logic         Out_Valid, Hit_Any;
    logic [2:0]   Hit_Lane;

    lane_object_compositor #(
        .LANES(LANES), .SLOTS(SLOTS), .OBJ_W(OBJ_W), .OBJ_H(OBJ_H),
        .FLASH_FRAMES(FF), .BG_RGB(BG), .FLASH_RGB(FL)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Frame_Start(Frame_Start),
        .Wr_En(Wr_En), .Wr_Lane(Wr_Lane), .Wr_Slot(Wr_Slot),
        .Wr_X(Wr_X), .Wr_Y(Wr_Y), .Wr_Vis(Wr_Vis),
        .Lane_RGB(Lane_RGB), .Flash_Req(Flash_Req),
        .Pix_Valid(Pix_Valid), .DrawX(DrawX), .DrawY(DrawY),
        .Red(Red), .Green(Green), .Blue(Blue),
        .Out_Valid(Out_Valid), .Hit_Any(Hit_Any), .Hit_Lane(Hit_Lane)
    );

    initial begin
        Clk = 0;
        forever #5 Clk = ~Clk;
    end

    int n_chk = 0;
    int n_pass = 0;

    // Reference model state: object tables, flash counters, lane colours.
    int          sh_x [LANES][SLOTS], sh_y [LANES][SLOTS];
    bit          sh_v [LANES][SLOTS];
    int          ac_x [LANES][SLOTS], ac_y [LANES][SLOTS];
    bit          ac_v [LANES][SLOTS];
    int          cnt  [LANES];
    logic [23:0] lane_col [LANES];
    bit          pend_vld;
    bit          pend_any;
    int          pend_lane;
    logic [27:0] exp_q [$];
    logic [27:0] last_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic void model_reset();
        for (int l = 0; l < LANES; l++) begin
            cnt[l] = 0;
            for (int s = 0; s < SLOTS; s++) begin
                sh_x[l][s] = 0; sh_y[l][s] = 0; sh_v[l][s] = 0;
                ac_x[l][s] = 0; ac_y[l][s] = 0; ac_v[l][s] = 0;
            end
        end
        pend_vld = 0;
        exp_q.delete();
        last_exp = '0;
    endfunction

    function automatic void set_colours();
        for (int l = 0; l < LANES; l++) begin
            lane_col[l] = 24'($urandom);
            Lane_RGB[l*24 +: 24] = lane_col[l];
        end
    endfunction

    function automatic void classify(input int px, input int py, output bit any, output int lane);
        any = 0;
        lane = 0;
        for (int l = 0; l < LANES && !any; l++)
            for (int s = 0; s < SLOTS; s++)
                if (ac_v[l][s] && (((px - ac_x[l][s]) & 2047) < OBJ_W)
                               && (((py - ac_y[l][s]) & 2047) < OBJ_H)) begin
                    any = 1;
                    lane = l;
                end
    endfunction

    // One clock of stimulus; the model's prediction for the previous pixel is pushed
    // with the flash counters as they stand before this cycle's updates.
    task automatic step(input bit fs, input bit we, input int wl, input int ws, input int wx,
                        input int wy, input bit wv, input logic [7:0] freq, input bit pv,
                        input int px, input int py);
        logic [23:0] rgb;
        Frame_Start = fs; Wr_En = we; Wr_Lane = 3'(wl); Wr_Slot = 2'(ws);
        Wr_X = 11'(wx); Wr_Y = 11'(wy); Wr_Vis = wv; Flash_Req = freq;
        Pix_Valid = pv; DrawX = 11'(px); DrawY = 11'(py);
        if (pend_vld) begin
            if (!pend_any) rgb = BG;
            else if (cnt[pend_lane] % 2 == 1) rgb = FL;
            else rgb = lane_col[pend_lane];
            exp_q.push_back({rgb, pend_any, 3'(pend_any ? pend_lane : 0)});
        end
        pend_vld = pv;
        if (pv) classify(px & 2047, py & 2047, pend_any, pend_lane);
        for (int l = 0; l < LANES; l++) begin
            if (freq[l]) cnt[l] = FF;
            else if (fs && cnt[l] > 0) cnt[l]--;
        end
        if (fs) begin
            ac_x = sh_x; ac_y = sh_y; ac_v = sh_v;
        end
        if (we) begin
            sh_x[wl][ws] = wx & 2047; sh_y[wl][ws] = wy & 2047; sh_v[wl][ws] = wv;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    endtask
    task automatic wr(input int l, input int s, input int x, input int y, input bit v);
        step(0, 1, l, s, x, y, v, 8'h00, 0, 0, 0);
    endtask
    task automatic frame();
        step(1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    endtask
    task automatic pix(input int x, input int y);
        step(0, 0, 0, 0, 0, 0, 0, 8'h00, 1, x, y);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_rgb"}, 32'({Red, Green, Blue}), 32'h0);
        chk({tag, "_out_valid"}, 32'(Out_Valid), 32'h0);
        chk({tag, "_hit_any"}, 32'(Hit_Any), 32'h0);
        chk({tag, "_hit_lane"}, 32'(Hit_Lane), 32'h0);
    endtask

    always @(negedge Clk) begin
        logic [27:0] act;
        logic [27:0] e;
        if (Reset_n) begin
            act = {Red, Green, Blue, Hit_Any, Hit_Lane};
            if (Out_Valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 32'h1, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pixel", 32'(act), 32'(e));
                    last_exp = e;
                end
            end else begin
                chk("hold", 32'(act), 32'(last_exp));
            end
        end
    end

    initial begin
        int l, s, px, py;
        logic [7:0] fr;
        Reset_n = 1;
        Frame_Start = 0; Wr_En = 0; Wr_Lane = 0; Wr_Slot = 0; Wr_X = 0; Wr_Y = 0; Wr_Vis = 0;
        Flash_Req = 0; Pix_Valid = 0; DrawX = 0; DrawY = 0; Lane_RGB = '0;
        model_reset();
        set_colours();
        #2 Reset_n = 0;
        #1 check_zero_outputs("reset");
        repeat (3) @(posedge Clk);
        #2 Reset_n = 1;
        @(posedge Clk);
        #1;
        idle(2);

        // Basic hit and object edges
        wr(2, 0, 100, 40, 1);
        frame();
        pix(100, 40); pix(180, 40); pix(179, 79); pix(100, 80); pix(99, 40);
        idle(3);

        // Wrap-around on X
        wr(0, 1, 2040, 0, 1);
        frame();
        pix(5, 0); pix(72, 0); pix(2039, 0); pix(71, 0); pix(2047, 39);
        idle(2);

        // Priority between overlapping lanes
        wr(1, 2, 280, 180, 1);
        wr(5, 3, 290, 190, 1);
        frame();
        pix(300, 200); pix(365, 200); pix(300, 225);
        idle(2);

        // Double buffering, including a pixel and a write coincident with Frame_Start
        wr(2, 0, 500, 40, 1);
        pix(100, 40); pix(500, 40);
        step(1, 1, 2, 0, 900, 40, 1, 8'h00, 1, 100, 40);
        pix(500, 40); pix(900, 40); pix(100, 40);
        frame();
        pix(900, 40); pix(500, 40);
        idle(2);

        // Flash on lane 3, lane 1 unaffected, reload coincident with Frame_Start
        wr(3, 0, 600, 300, 1);
        frame();
        step(0, 0, 0, 0, 0, 0, 0, 8'h08, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            pix(600, 300); pix(300, 200);
            frame();
        end
        step(0, 0, 0, 0, 0, 0, 0, 8'h08, 0, 0, 0);
        frame(); frame();
        step(1, 0, 0, 0, 0, 0, 0, 8'h08, 1, 600, 300);
        pix(600, 300);
        frame();
        pix(600, 300);
        idle(2);

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            if (i % 700 == 0) set_colours();
            l = $urandom_range(0, LANES - 1);
            s = $urandom_range(0, SLOTS - 1);
            if ($urandom_range(0, 3) != 0) begin
                px = ac_x[l][s] + $urandom_range(0, 99) - 10;
                py = ac_y[l][s] + $urandom_range(0, 59) - 10;
            end else begin
                px = $urandom_range(0, 2047);
                py = $urandom_range(0, 2047);
            end
            fr = ($urandom_range(0, 39) == 0) ? 8'($urandom) : 8'h00;
            step($urandom_range(0, 24) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, LANES - 1), $urandom_range(0, SLOTS - 1),
                 ($urandom_range(0, 5) == 0) ? $urandom_range(1990, 2047) : $urandom_range(0, 700),
                 $urandom_range(0, 500), $urandom_range(0, 3) != 0,
                 fr, $urandom_range(0, 9) < 7, px, py);
        end

        // Reset while pixels stream, then everything renders background
        pix(600, 300); pix(100, 40);
        #1 Reset_n = 0;
        #1 check_zero_outputs("mid_reset");
        Pix_Valid = 0; Frame_Start = 0; Wr_En = 0; Flash_Req = 0;
        model_reset();
        repeat (2) @(posedge Clk);
        #2 Reset_n = 1;
        @(posedge Clk);
        #1;
        for (int i = 0; i < 40; i++) begin
            if (i % 10 == 0) frame();
            pix($urandom_range(0, 700), $urandom_range(0, 500));
        end
        wr(4, 1, 50, 60, 1);
        frame();
        pix(60, 70); pix(10, 70);
        idle(4);

        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
